// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex pattern table, blank pattern and the
// handshake state type used by the capture path (and the display encoder).
package seg7_pkg;

   typedef logic [0:6] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   // Index is the hex digit; bit 0 of each entry is segment a.
   localparam seg_t SEG_TABLE [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } hs_state_e;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one normalised 7-segment pattern to a hex nibble,
// flagging table hits (valid) and the all-off pattern (blank).
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [0:6] seg,
   output logic [3:0] nibble,
   output logic       valid,
   output logic       blank
);

   always_comb begin
      nibble = 4'h0;
      valid  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            nibble = 4'(i);
            valid  = 1'b1;
         end
      end
      blank = (seg == SEG_BLANK);
   end

endmodule

// File: rtl/seg7_byte_capture.sv
// Captures two asynchronous 7-segment digit buses, waits for a stable pattern,
// decodes it to a byte and offers it to a consumer over valid/ready.
module seg7_byte_capture
   import seg7_pkg::*;
#(
   parameter int INPUT_POLARITY = 1,
   parameter int STABLE_CYCLES  = 4
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [0:6] Msq,
   input  logic [0:6] Lsq,
   output logic [7:0] Byte,
   output logic       Valid,
   input  logic       Ready,
   output logic       Error,
   output logic       Overrun,
   input  logic       ClrOvr
);

   // Raw value that normalises to blank, so reset looks like an unlit display.
   localparam logic [13:0] RAW_BLANK  = (INPUT_POLARITY != 0) ? 14'h0000 : 14'h3fff;
   localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYCLES);

   logic [13:0] sync1_q, sync2_q, prev_q;
   logic [13:0] norm;
   logic [0:6]  msq_n, lsq_n;
   logic [7:0]  cnt_q, cnt_d;
   logic        changed, accept, deliver, bad;
   logic [3:0]  m_nib, l_nib;
   logic        m_valid, m_blank, l_valid, l_blank;
   hs_state_e   state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic        error_q, error_d;
   logic        ovr_q, ovr_d;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1_q <= RAW_BLANK;
         sync2_q <= RAW_BLANK;
         prev_q  <= RAW_BLANK;
      end else begin
         sync1_q <= {Msq, Lsq};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign norm  = (INPUT_POLARITY != 0) ? sync2_q : ~sync2_q;
   assign msq_n = norm[13:7];
   assign lsq_n = norm[6:0];

   seg7_digit_decode u_dec_ms (.seg(msq_n), .nibble(m_nib), .valid(m_valid), .blank(m_blank));
   seg7_digit_decode u_dec_ls (.seg(lsq_n), .nibble(l_nib), .valid(l_valid), .blank(l_blank));

   // Accept fires on the cycle the run length first reaches the limit; the
   // 'changed' term covers STABLE_CYCLES=1, where the count never moves.
   always_comb begin
      changed = (sync2_q != prev_q);
      if (changed)                  cnt_d = 8'd1;
      else if (cnt_q == STABLE_LIM) cnt_d = cnt_q;
      else                          cnt_d = cnt_q + 8'd1;
      accept  = (cnt_d == STABLE_LIM) && (changed || (cnt_q != STABLE_LIM));
      deliver = accept && m_valid && l_valid;
      bad     = accept && ((!m_valid && !m_blank) || (!l_valid && !l_blank));
   end

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      error_d = bad;
      ovr_d   = ovr_q;
      if (ClrOvr) ovr_d = 1'b0;
      case (state_q)
         EMPTY: begin
            if (deliver) begin
               byte_d  = {m_nib, l_nib};
               state_d = FULL;
            end
         end
         FULL: begin
            if (Ready) begin
               if (deliver) byte_d  = {m_nib, l_nib};
               else         state_d = EMPTY;
            end else if (deliver) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q   <= 8'd0;
         state_q <= EMPTY;
         byte_q  <= 8'h00;
         error_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         byte_q  <= byte_d;
         error_q <= error_d;
         ovr_q   <= ovr_d;
      end
   end

   assign Byte    = byte_q;
   assign Valid   = (state_q == FULL);
   assign Error   = error_q;
   assign Overrun = ovr_q;

endmodule

// File: doc/seg7_byte_capture.md
Name: seg7_byte_capture

Overview:
- Reverse path of the hex-to-7-segment display encoder.
- Samples a pair of 7-segment digit buses (MS digit, LS digit), waits until the pattern is stable, and decodes it back to an 8-bit byte.
- Hands the byte to a consumer over a valid/ready handshake.
- Used on the board-loopback and external-display-snoop paths, where segment lines arrive asynchronous to Clk.

Parameters:
- INPUT_POLARITY, 1: 1 = segment lit when '1'; 0 = segment lit when '0' (all inputs inverted before use).
- STABLE_CYCLES, 4: consecutive synchronised cycles a pattern must hold before acceptance; legal range 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Msq  in  [0:6]  MS digit segments a..g (index 0 = a), async.
- Lsq  in  [0:6]  LS digit segments a..g, async.
- Byte  out  [7:0]  decoded byte; Byte[7:4] from Msq, Byte[3:0] from Lsq.
- Valid  out  1  Byte holds an undelivered value.
- Ready  in  1  consumer accepts Byte when Valid=1.
- Error  out  1  one-cycle pulse: a stable pattern was not decodable.
- Overrun  out  1  sticky: a stable byte was dropped because Valid=1 and Ready=0.
- ClrOvr  in  1  synchronous clear of Overrun.

Behaviour:
- Reset (Rst_n=0, asynchronous) sets:
  - Byte=8'h00, Valid=0, Error=0, Overrun=0.
  - Sync flops to the normalised blank pattern 7'b0000000.
  - Run counter = 0, FSM = EMPTY.
- Reset mid-operation discards any pending byte. After release, the block operates from the next edge.
- Input path:
  - 2-flop synchroniser on all 14 bits.
  - Then polarity normalisation: invert if INPUT_POLARITY=0.
- Decode table (normalised, a..g), per digit:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - 0000000 = blank.
  - Anything else = invalid.
- Stability:
  - Run counter resets to 1 when the synchronised 14-bit pattern differs from its previous-cycle value.
  - Otherwise it increments, saturating at STABLE_CYCLES.
  - An accept event fires exactly once per run, on the cycle the counter reaches STABLE_CYCLES.
- Accept event classification:
  - Both digits valid: deliver byte.
  - Either digit invalid: Error=1 for one cycle; nothing delivered.
  - Otherwise (blank plus valid, or both blank): silent, no delivery, no Error.
- Latency: a clean input change held steady produces Valid=1 (or the Error pulse) after the (STABLE_CYCLES+2)th rising edge following the change.
- Handshake FSM:
  - EMPTY: deliver loads Byte, sets Valid=1, goes to FULL.
  - FULL, Ready=1, no deliver: handshake completes, Valid=0, goes to EMPTY.
  - FULL, Ready=1, deliver on the same cycle: the old byte is consumed, the new byte is loaded, Valid stays 1, FSM stays FULL.
  - FULL, Ready=0, deliver: the new byte is dropped, Byte is unchanged, Overrun is set.
  - Byte is stable whenever Valid=1 and Ready=0.
  - Ready is ignored when Valid=0.
- Overrun:
  - Held until ClrOvr=1 (cleared next edge).
  - If set and ClrOvr occur on the same cycle, set wins.
- The same value held forever yields one delivery. Returning to a value after a change yields a new delivery.

Decomposition:
- Package seg7_pkg holds:
  - The 16-entry segment pattern table constant.
  - The SEG_BLANK constant.
  - The FSM state type {EMPTY, FULL}.
- The display encoder also reuses the pattern table from seg7_pkg.
- Sub-module seg7_digit_decode:
  - Combinational 7-bit pattern to {nibble, valid, blank}.
  - Instantiated twice (Msq, Lsq).

Test Plan:
- Reset, then Msq=1111001 (3), Lsq=1110111 (A), STABLE_CYCLES=4, Ready=0 -> Valid rises after edge 6; Byte=8'h3A; Error=0.
- With 8'h3A pending and Ready=0, drive Msq=0110000, Lsq=0110000 (8'h11) stable -> Overrun=1; Byte stays 8'h3A. Then Ready=1 for one cycle -> Valid=0. Then ClrOvr=1 -> Overrun=0.
- Toggle Lsq between 0 and 8 every 3 cycles (STABLE_CYCLES=4) -> no Valid, no Error. Then hold Lsq=8, Msq=F (1000111) -> Byte=8'hF8 once.
- Hold Msq=1010101 (invalid), Lsq=1111110 -> exactly one Error pulse; Valid stays 0.
- Ready held 1, change input 8'h12 to 8'h34, with the accept event landing on the cycle Ready consumes 8'h12 -> Valid stays 1; Byte=8'h34 next cycle; no Overrun.
- INPUT_POLARITY=0, drive ~1011011 (5) on both digits -> Byte=8'h55. Assert Rst_n=0 while Valid=1 -> Valid=0 and Byte=8'h00 immediately, without a clock edge.
